// File: rtl/layer2_pkg.sv
// Shared definitions for the layer-2 back end (bias loader and bias/argmax stage).
// Holds the layer dimensions, bias alignment and the controller state encoding.
package layer2_pkg;

    localparam int OUT_SIZE   = 10;   // output neurons / classes
    localparam int W          = 8;    // bias width, signed
    localparam int ACC_W      = 24;   // accumulator / logit width, signed
    localparam int BIAS_SHIFT = 0;    // bias fixed point -> accumulator fixed point
    localparam int IDX_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BIAS = 2'd1,
        SCAN      = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/sat_add_signed.sv
// Saturating signed adder: y = sat(a + (sign_extend(b) << SHIFT)) at A_W bits.
// Ports:
//   a  in  A_W  signed addend (accumulator)
//   b  in  B_W  signed addend (bias), sign-extended and aligned by SHIFT
//   y  out A_W  signed sum clamped to [-2^(A_W-1), 2^(A_W-1)-1]
module sat_add_signed #(
    parameter int A_W   = 24,
    parameter int B_W   = 8,
    parameter int SHIFT = 0
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] y
);

    logic [A_W-1:0] b_ext;
    logic [A_W:0]   sum;

    assign b_ext = {{(A_W-B_W){b[B_W-1]}}, b} << SHIFT;

    // One guard bit is enough for a two-operand add; overflow shows up as
    // disagreement between the guard bit and the A_W-bit sign.
    assign sum = {a[A_W-1], a} + {b_ext[A_W-1], b_ext};

    always_comb begin
        y = sum[A_W-1:0];
        if (sum[A_W] != sum[A_W-1]) begin
            y = sum[A_W] ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/layer2_bias_argmax.sv
// Final stage of layer 2: adds the aligned bias to each captured MAC sum with
// saturation, publishes the logits and scans them one per cycle for the maximum.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   start       pulse; captures acc_in and begins (only from IDLE or DONE)
//   acc_in      OUT_SIZE packed MAC sums, neuron i at [i*ACC_W +: ACC_W]
//   bias_in     OUT_SIZE packed biases, neuron i at [i*W +: W]
//   bias_valid  bias loader finished, bias_in stable while high
//   logits      biased, saturated logits, same packing as acc_in
//   class_idx   index of the maximum logit (lowest index wins ties)
//   max_val     value of the maximum logit
//   busy        high in WAIT_BIAS and SCAN
//   done        high in DONE
module layer2_bias_argmax
    import layer2_pkg::state_t;
    import layer2_pkg::IDLE;
    import layer2_pkg::WAIT_BIAS;
    import layer2_pkg::SCAN;
    import layer2_pkg::DONE;
#(
    parameter int OUT_SIZE   = layer2_pkg::OUT_SIZE,
    parameter int W          = layer2_pkg::W,
    parameter int ACC_W      = layer2_pkg::ACC_W,
    parameter int BIAS_SHIFT = layer2_pkg::BIAS_SHIFT,
    parameter int IDX_W      = layer2_pkg::IDX_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [OUT_SIZE*ACC_W-1:0] acc_in,
    input  logic [OUT_SIZE*W-1:0]     bias_in,
    input  logic                      bias_valid,
    output logic [OUT_SIZE*ACC_W-1:0] logits,
    output logic [IDX_W-1:0]          class_idx,
    output logic [ACC_W-1:0]          max_val,
    output logic                      busy,
    output logic                      done
);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [ACC_W-1:0]   acc_r      [OUT_SIZE];
    logic [ACC_W-1:0]   logits_reg [OUT_SIZE];
    logic [W-1:0]       bias_arr   [OUT_SIZE];
    logic [ACC_W-1:0]   max_reg;
    logic [IDX_W-1:0]   class_reg;

    logic [ACC_W-1:0]   acc_sel;
    logic [W-1:0]       bias_sel;
    logic [ACC_W-1:0]   sum;
    logic               capture;
    logic               last_idx;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_SIZE; gi++) begin : g_unpack
            assign bias_arr[gi]                 = bias_in[gi*W +: W];
            assign logits[gi*ACC_W +: ACC_W]    = logits_reg[gi];
        end
    endgenerate

    // Neuron currently being scanned.
    assign acc_sel  = acc_r[idx_reg];
    assign bias_sel = bias_arr[idx_reg];
    assign last_idx = (idx_reg == IDX_W'(OUT_SIZE - 1));

    sat_add_signed #(
        .A_W   (ACC_W),
        .B_W   (W),
        .SHIFT (BIAS_SHIFT)
    ) u_sat_add (
        .a (acc_sel),
        .b (bias_sel),
        .y (sum)
    );

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    capture    = 1'b1;
                    state_next = WAIT_BIAS;
                end
            end
            WAIT_BIAS: begin
                if (bias_valid) state_next = SCAN;
            end
            SCAN: begin
                if (last_idx) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            max_reg   <= '0;
            class_reg <= '0;
            for (int i = 0; i < OUT_SIZE; i++) begin
                acc_r[i]      <= '0;
                logits_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (capture) begin
                idx_reg <= '0;
                for (int i = 0; i < OUT_SIZE; i++) begin
                    acc_r[i] <= acc_in[i*ACC_W +: ACC_W];
                end
            end
            if (state_reg == SCAN) begin
                logits_reg[idx_reg] <= sum;
                // Index 0 seeds the running maximum; strict compare keeps
                // the lowest index on ties.
                if ((idx_reg == '0) || ($signed(sum) > $signed(max_reg))) begin
                    max_reg   <= sum;
                    class_reg <= idx_reg;
                end
                if (!last_idx) idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign class_idx = class_reg;
    assign max_val   = max_reg;
    assign busy      = (state_reg == WAIT_BIAS) || (state_reg == SCAN);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_layer2_bias_argmax.sv
// Directed bench for layer2_bias_argmax with a scoreboard of expected results.
module tb_layer2_bias_argmax;

    localparam int N  = 10;
    localparam int AW = 24;
    localparam int BW = 8;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [N*AW-1:0]   acc_in;
    logic [N*BW-1:0]   bias_in;
    logic              bias_valid;
    logic [N*AW-1:0]   logits;
    logic [IW-1:0]     class_idx;
    logic [AW-1:0]     max_val;
    logic              busy;
    logic              done;

    int acc_v  [N];
    int bias_v [N];
    logic [31:0] exp_q [$];
    int passed = 0;
    int total  = 0;

    layer2_bias_argmax dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .acc_in     (acc_in),
        .bias_in    (bias_in),
        .bias_valid (bias_valid),
        .logits     (logits),
        .class_idx  (class_idx),
        .max_val    (max_val),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [AW-1:0] sat(input int a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 64'sd8388607)  s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
        return AW'(s);
    endfunction

    function automatic logic [AW-1:0] dut_logit(input int i);
        return logits[i*AW +: AW];
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            acc_in[i*AW +: AW]  = AW'(acc_v[i]);
            bias_in[i*BW +: BW] = BW'(bias_v[i]);
        end
    endtask

    // Reference: saturated logits, then strict-greater argmax (lowest index on ties).
    task automatic push_expected();
        logic [AW-1:0] e [N];
        int best;
        for (int i = 0; i < N; i++) e[i] = sat(acc_v[i], bias_v[i]);
        best = 0;
        for (int i = 1; i < N; i++)
            if ($signed(e[i]) > $signed(e[best])) best = i;
        for (int i = 0; i < N; i++) exp_q.push_back(32'(e[i]));
        exp_q.push_back(32'(e[best]));
        exp_q.push_back(32'(best));
    endtask

    task automatic compare_result(input string run);
        if (exp_q.size() < N + 2) begin
            chk({run, "_scoreboard_empty"}, 32'(exp_q.size()), 32'(N + 2));
        end else begin
            for (int i = 0; i < N; i++)
                chk($sformatf("%s_logit%0d", run, i), 32'(dut_logit(i)), exp_q.pop_front());
            chk({run, "_max_val"},   32'(max_val),   exp_q.pop_front());
            chk({run, "_class_idx"}, 32'(class_idx), exp_q.pop_front());
        end
        $display("run %s: class_idx=%0d max_val=%0d", run, class_idx, $signed(max_val));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges (starting from `cycles`) until done is seen, bounded.
    task automatic wait_done(input int init, output int cycles);
        cycles = init;
        while (!done && cycles < 300) begin
            @(posedge clk);
            #1 cycles++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int cyc;
        logic busy_ok;
        logic [AW-1:0] prev_logit0;

        rst_n = 1'b0; start = 1'b0; bias_valid = 1'b0;
        acc_in = '0; bias_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_logits", 32'(|logits), 32'd0);
        chk("rst_class",  32'(class_idx), 32'd0);
        chk("rst_max",    32'(max_val), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: ascending accumulators, zero bias, bias already valid
        for (int i = 0; i < N; i++) begin acc_v[i] = i * 10; bias_v[i] = 0; end
        drive_inputs(); bias_valid = 1'b1; push_expected();
        do_start();
        wait_done(1, cyc);
        chk("t1_latency", 32'(cyc), 32'd12);
        compare_result("t1");

        // 2: tie between 3 and 7
        for (int i = 0; i < N; i++) begin acc_v[i] = 100; bias_v[i] = 0; end
        bias_v[3] = 5; bias_v[7] = 5;
        drive_inputs(); push_expected();
        do_start();
        wait_done(1, cyc);
        compare_result("t2");

        // 3: positive and negative saturation
        for (int i = 0; i < N; i++) begin acc_v[i] = i - 50; bias_v[i] = 1; end
        acc_v[0] = 8388606;  bias_v[0] = 127;
        acc_v[1] = -8388607; bias_v[1] = -128;
        drive_inputs(); push_expected();
        do_start();
        wait_done(1, cyc);
        compare_result("t3");

        // 4: bias arrives late; all logits negative
        bias_valid = 1'b0;
        for (int i = 0; i < N; i++) begin acc_v[i] = -1000 - i * 37; bias_v[i] = -(i + 1); end
        acc_v[6] = -5;
        drive_inputs(); push_expected();
        do_start();
        busy_ok = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1 if (!busy || done) busy_ok = 1'b0;
        end
        chk("t4_busy_wait", 32'(busy_ok), 32'd1);
        bias_valid = 1'b1;
        wait_done(0, cyc);
        chk("t4_latency", 32'(cyc), 32'd11);
        compare_result("t4");

        // 5: asynchronous reset in the middle of the scan (idx = 4)
        for (int i = 0; i < N; i++) begin acc_v[i] = 500 - i; bias_v[i] = 3; end
        drive_inputs();
        do_start();
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_logits", 32'(|logits), 32'd0);
        chk("t5_rst_class",  32'(class_idx), 32'd0);
        chk("t5_rst_max",    32'(max_val), 32'd0);
        chk("t5_rst_busy",   32'(busy), 32'd0);
        chk("t5_rst_done",   32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        push_expected();
        do_start();
        wait_done(1, cyc);
        chk("t5_latency", 32'(cyc), 32'd12);
        compare_result("t5");

        // 6: start during scan is ignored; start in DONE restarts
        for (int i = 0; i < N; i++) begin acc_v[i] = (i * 7919) % 1000 - 400; bias_v[i] = i - 5; end
        drive_inputs(); push_expected();
        do_start();
        repeat (3) @(posedge clk);
        for (int i = 0; i < N; i++) acc_v[i] = 100000 + i;
        drive_inputs();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(5, cyc);
        chk("t6_latency", 32'(cyc), 32'd12);
        prev_logit0 = sat((0 * 7919) % 1000 - 400, -5);
        compare_result("t6a");
        for (int i = 0; i < N; i++) begin acc_v[i] = 20 * i - 90; bias_v[i] = 9 - i; end
        drive_inputs(); push_expected();
        do_start();
        chk("t6_done_drop",  32'(done), 32'd0);
        chk("t6_busy_rise",  32'(busy), 32'd1);
        chk("t6_logit_hold", 32'(dut_logit(0)), 32'(prev_logit0));
        wait_done(1, cyc);
        chk("t6b_latency", 32'(cyc), 32'd12);
        compare_result("t6b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
